// File: rtl/pipelined_mult_hs_if.sv
// Operand/result handshake bundle for the pipelined multiplier.
// master: producer/consumer side; slave: the multiplier.
interface pipelined_mult_hs_if #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int STAGE_BITS = 1
);
  localparam int S     = N / STAGE_BITS;
  localparam int OCC_W = $clog2(S + 2);

  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [M-1:0]       a;
  logic [N-1:0]       b;
  logic               out_valid;
  logic               out_ready;
  logic [M+N-1:0]     result;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, result, occupancy
  );

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, result, occupancy
  );
endinterface

// File: rtl/pipelined_mult_hs.sv
// Pipelined M x N shift-and-add multiplier with valid/ready on both sides.
// Stage 0 captures operand magnitudes and the result sign; stages 1..S each
// retire STAGE_BITS multiplier bits. The whole pipe stalls when the output
// holds an unaccepted result.
module pipelined_mult_hs #(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int STAGE_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_mult_hs_if.slave mul
);
  localparam int unsigned SB    = STAGE_BITS;
  localparam int unsigned S     = N / STAGE_BITS;
  localparam int unsigned W     = M + N;
  localparam int unsigned OCC_W = $clog2(S + 2);

  if ((N % STAGE_BITS) != 0) begin : g_bad_stage_bits
    $error("pipelined_mult_hs: STAGE_BITS must divide N");
  end

  logic [S:0]          valid_q, valid_d;
  logic [S:0][M-1:0]   mag_a_q, mag_a_d;
  logic [S:0][N-1:0]   mag_b_q, mag_b_d;
  logic [S:0]          neg_q,   neg_d;
  logic [S:0][W-1:0]   acc_q,   acc_d;
  logic [OCC_W-1:0]    occ_q,   occ_d;

  logic                advance;
  logic                accept;
  logic                retire;
  logic [SB-1:0]       slice;
  logic [W-1:0]        pp;

  assign advance       = ~valid_q[S] | mul.out_ready;
  assign accept        = mul.in_valid & advance;
  assign retire        = valid_q[S] & mul.out_ready;

  assign mul.in_ready  = advance;
  assign mul.out_valid = valid_q[S];
  assign mul.result    = neg_q[S] ? -acc_q[S] : acc_q[S];
  assign mul.occupancy = occ_q;

  // Next state: all stages shift together on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    slice   = '0;
    pp      = '0;
    // Occupancy tracks popcount(valid) incrementally: one in, one out.
    occ_d   = occ_q + OCC_W'(accept) - OCC_W'(retire);
    if (advance) begin
      valid_d = {valid_q[S-1:0], accept};
      if (accept) begin
        mag_a_d[0] = (mul.in_signed && mul.a[M-1]) ? -mul.a : mul.a;
        mag_b_d[0] = (mul.in_signed && mul.b[N-1]) ? -mul.b : mul.b;
        neg_d[0]   = mul.in_signed & (mul.a[M-1] ^ mul.b[N-1]);
        acc_d[0]   = '0;
      end
      for (int unsigned k = 1; k <= S; k++) begin
        slice      = mag_b_q[k-1][(k-1)*SB +: SB];
        pp         = (W'(mag_a_q[k-1]) * W'(slice)) << ((k-1)*SB);
        acc_d[k]   = acc_q[k-1] + pp;
        mag_a_d[k] = mag_a_q[k-1];
        mag_b_d[k] = mag_b_q[k-1];
        neg_d[k]   = neg_q[k-1];
      end
    end
  end

  // Pipeline registers with synchronous reset discarding in-flight ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= '0;
      acc_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      occ_q   <= occ_d;
    end
  end
endmodule
